// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write arbiter (fifo_wr_arb, rr_pick).
// Optional grant statistics are enabled with FIFO_WR_ARB_STATS_EN.
package fifo_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam int unsigned STAT_W = 16;

  // Index width for v items; never below 1 so single-bit selectors stay legal.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority encoder: first set request at or above ptr, wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  int unsigned k;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    k     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      k = (32'(ptr) + i) % N;
      if (!valid && req[k]) begin
        valid  = 1'b1;
        idx    = IDX_W'(k);
        gnt[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin, burst-locking write arbiter in front of a sync_fifo write port.
// Define FIFO_WR_ARB_STATS_EN to add per-requester saturating grant counters.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           req_last,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  output logic [N_REQ-1:0]           gnt,
  input  logic                       fifo_full,
  output logic                       fifo_wr,
  output logic [DATA_W-1:0]          fifo_data_in,
  output logic [clog2(N_REQ)-1:0]    owner,
  output logic                       busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  input  logic [clog2(N_REQ)-1:0]    stat_sel,
  input  logic                       stat_clr,
  output logic [STAT_W-1:0]          stat_cnt
`endif
);

  localparam int unsigned IDX_W = clog2(N_REQ);
  localparam int unsigned CNT_W = clog2(MAX_BURST + 1);

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   beat_cnt;

  logic [N_REQ-1:0]   pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   next_ptr;
  logic               burst_end;

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    gnt = '0;
    if (rst_n && !fifo_full) begin
      if (state == ARB) begin
        if (pick_valid) gnt = pick_gnt;
      end else if (req[owner]) begin
        gnt[owner] = 1'b1;
      end
    end
  end

  always_comb begin
    fifo_data_in = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt[i]) fifo_data_in = req_data[i*DATA_W +: DATA_W];
    end
  end

  assign fifo_wr  = |gnt;
  assign win_idx  = (state == ARB) ? pick_idx : owner;
  assign next_ptr = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
  // beat_cnt is 0 in ARB, so this single compare also covers MAX_BURST==1.
  assign burst_end = req_last[win_idx] || (beat_cnt == CNT_W'(MAX_BURST - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      owner    <= '0;
      busy     <= 1'b0;
    end else if (fifo_wr) begin
      owner <= win_idx;
      if (burst_end) begin
        state    <= ARB;
        rr_ptr   <= next_ptr;
        beat_cnt <= '0;
        busy     <= 1'b0;
      end else begin
        state    <= LOCK;
        beat_cnt <= beat_cnt + 1'b1;
        busy     <= 1'b1;
      end
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [STAT_W-1:0] stat_q [N_REQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_REQ; i++) stat_q[i] <= '0;
    end else if (stat_clr) begin
      for (int unsigned i = 0; i < N_REQ; i++) stat_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (gnt[i] && stat_q[i] != '1) stat_q[i] <= stat_q[i] + 1'b1;
      end
    end
  end

  assign stat_cnt = (32'(stat_sel) < N_REQ) ? stat_q[stat_sel] : '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb with a depth-8 FIFO model and a rule-level reference.
// Stats checks are compiled only when FIFO_WR_ARB_STATS_EN is defined.
module tb_fifo_wr_arb;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int MAXB  = 4;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N-1:0]  req_last;
  logic [N*DW-1:0] rdata;
  logic [N-1:0]  gnt;
  logic          fifo_full;
  logic          fifo_wr;
  logic [DW-1:0] fifo_data_in;
  logic [1:0]    owner;
  logic          busy;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [1:0]    stat_sel;
  logic          stat_clr;
  logic [15:0]   stat_cnt;
`endif

  fifo_wr_arb #(
    .N_REQ     (N),
    .DATA_W    (DW),
    .MAX_BURST (MAXB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_last     (req_last),
    .req_data     (rdata),
    .gnt          (gnt),
    .fifo_full    (fifo_full),
    .fifo_wr      (fifo_wr),
    .fifo_data_in (fifo_data_in),
    .owner        (owner),
    .busy         (busy)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .stat_sel     (stat_sel),
    .stat_clr     (stat_clr),
    .stat_cnt     (stat_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference: whether a burst is open, who owns it, beats taken so far, next scan start.
  bit          m_locked;
  int          m_owner;
  int          m_beats;
  int          m_ptr;
  int          mcnt [N];

  logic [DW-1:0] fq [$];
  logic [DW-1:0] mq [$];
  logic          rd_en;
  bit            inc_en;
  logic [N-1:0]  last_eg;
  logic [N-1:0]  last_obs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] model_gnt();
    logic [N-1:0] g;
    g = '0;
    if (!rst_n || fifo_full) return g;
    if (m_locked) begin
      if (req[m_owner]) g[m_owner] = 1'b1;
      return g;
    end
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (req[j]) begin
        g[j] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  task automatic model_reset();
    m_locked = 0;
    m_owner  = 0;
    m_beats  = 0;
    m_ptr    = 0;
    for (int i = 0; i < N; i++) mcnt[i] = 0;
  endtask

  task automatic model_accept(input logic [N-1:0] eg);
    int w;
    w = -1;
    for (int i = 0; i < N; i++) if (eg[i]) w = i;
    if (w < 0) return;
    if (mcnt[w] < 65535) mcnt[w]++;
    m_owner = w;
    m_beats++;
    if (req_last[w] || m_beats == MAXB) begin
      m_locked = 0;
      m_beats  = 0;
      m_ptr    = (w + 1) % N;
    end else begin
      m_locked = 1;
    end
  endtask

  // Called just after a falling edge; runs one full clock cycle.
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] rl, input logic rd);
    logic [N-1:0]  eg;
    logic [DW-1:0] ed;
    logic [DW-1:0] obs_d;
    logic          obs_w;
    logic [DW-1:0] a, b;
    req       = r;
    req_last  = rl;
    rd_en     = rd;
    fifo_full = (fq.size() == DEPTH);
    #1;
    eg = model_gnt();
    ed = '0;
    for (int i = 0; i < N; i++) if (eg[i]) ed = rdata[i*DW +: DW];
    chk("gnt", 32'(gnt), 32'(eg));
    chk("fifo_wr", 32'(fifo_wr), 32'(|eg));
    chk("fifo_data_in", 32'(fifo_data_in), 32'(ed));
    obs_w    = fifo_wr;
    obs_d    = fifo_data_in;
    last_obs = gnt;
    last_eg  = eg;
    @(posedge clk);
    if (rd_en && fq.size() > 0 && mq.size() > 0) begin
      a = fq.pop_front();
      b = mq.pop_front();
      chk("fifo_readback", 32'(a), 32'(b));
    end
    if (obs_w && fq.size() < DEPTH) fq.push_back(obs_d);
    if (|eg) mq.push_back(ed);
    model_accept(eg);
    if (inc_en) for (int i = 0; i < N; i++) if (eg[i]) rdata[i*DW +: DW] = rdata[i*DW +: DW] + 8'd1;
    #1;
    chk("owner", 32'(owner), 32'(m_owner));
    chk("busy", 32'(busy), 32'(m_locked));
    @(negedge clk);
  endtask

  task automatic drain();
    for (int n = 0; n < 2 * DEPTH && fq.size() > 0; n++) step('0, '0, 1'b1);
    chk("drained", 32'(fq.size()), 32'd0);
  endtask

  initial begin
    logic [N-1:0] pend;
    logic [N-1:0] plast;
    rst_n     = 1'b0;
    req       = '1;
    req_last  = '1;
    rdata     = 32'h40302010;
    fifo_full = 1'b0;
    rd_en     = 1'b0;
    inc_en    = 0;
    last_eg   = '0;
    last_obs  = '0;
`ifdef FIFO_WR_ARB_STATS_EN
    stat_sel  = '0;
    stat_clr  = 1'b0;
`endif
    model_reset();

    // Reset state with all requests asserted.
    @(negedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_fifo_wr", 32'(fifo_wr), 32'd0);
    chk("rst_data", 32'(fifo_data_in), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: round robin over four single-beat requesters, then read back.
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 4'b1111, 1'b0);
      chk("s1_rr", 32'(last_obs), 32'(4'b0001 << (i % 4)));
    end
    drain();

    // 2: burst on requester 2 against a single-beat requester 0.
    rdata  = 32'h000000A0 << 16 | 32'h00000055;
    inc_en = 1;
    for (int i = 0; i < 9; i++) step(4'b0101, 4'b0001, 1'b1);
    inc_en = 0;
    drain();

    // 3: fill the FIFO, hold off while full, resume on the cycle after a read.
    for (int i = 0; i < 10; i++) step(4'b0001, 4'b0001, 1'b0);
    chk("s3_full_gnt", 32'(last_obs), 32'd0);
    step(4'b0001, 4'b0001, 1'b1);
    step(4'b0001, 4'b0001, 1'b0);
    chk("s3_resume", 32'(last_obs), 32'(4'b0001));
    drain();

    // 4: locked owner stalls without a grant while others wait.
    step(4'b0010, 4'b0000, 1'b1);
    step(4'b0010, 4'b0000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(4'b1000, 4'b0000, 1'b1);
      chk("s4_stall_busy", 32'(busy), 32'd1);
    end
    step(4'b1010, 4'b0010, 1'b1);
    step(4'b1000, 4'b1000, 1'b1);
    chk("s4_next", 32'(last_obs), 32'(4'b1000));
    drain();

    // 5: asynchronous reset in the middle of a burst.
    step(4'b0100, 4'b0000, 1'b0);
    req      = 4'b0100;
    req_last = 4'b0000;
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("s5_gnt", 32'(gnt), 32'd0);
    chk("s5_fifo_wr", 32'(fifo_wr), 32'd0);
    chk("s5_busy", 32'(busy), 32'd0);
    chk("s5_owner", 32'(owner), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1001, 4'b1001, 1'b1);
    chk("s5_first", 32'(last_obs), 32'(4'b0001));
    drain();

    // Randomized traffic with protocol-respecting requesters and random reads.
    pend  = '0;
    plast = '0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i]  = 1'b1;
          plast[i] = ($urandom_range(0, 2) == 0);
          rdata[i*DW +: DW] = 8'($urandom);
        end
      end
      step(pend, plast, ($urandom_range(0, 2) != 0));
      pend = pend & ~last_eg;
    end

`ifdef FIFO_WR_ARB_STATS_EN
    for (int s = 0; s < N; s++) begin
      stat_sel = 2'(s);
      #1;
      chk("stat_cnt", 32'(stat_cnt), 32'(mcnt[s]));
    end
    stat_clr = 1'b1;
    step('0, '0, 1'b0);
    stat_clr = 1'b0;
    for (int i = 0; i < N; i++) mcnt[i] = 0;
    for (int s = 0; s < N; s++) begin
      stat_sel = 2'(s);
      #1;
      chk("stat_clr", 32'(stat_cnt), 32'(mcnt[s]));
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
